matmul_param_unit: RTL and testbench

MATMUL_PARAM_UNIT -- requirements
Module: matmul_param_unit

---
 rtl/matmul_pkg.sv | 60 ++++++
 rtl/matmul_param_unit_mac.sv | 52 +++++
 rtl/matmul_param_unit.sv | 145 ++++++++++++++
 tb/tb_matmul_param_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply unit.
// Define MATMUL_SAT_EN to make element reduction clamp instead of wrap.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    localparam int MAX_DW    = 16;
    localparam int MAX_ACC_W = 40;

`ifdef MATMUL_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct packed {
        logic              clip;
        logic [MAX_DW-1:0] val;
    } red_t;

    // Accumulator width that can hold N full-scale products without overflow.
    function automatic int acc_w_f(input int data_w, input int n);
        return 2 * data_w + $clog2(n);
    endfunction

    // Reduce a sign/zero-extended accumulator to data_w bits (clamp or wrap).
    function automatic red_t reduce_f(input logic signed [MAX_ACC_W-1:0] acc,
                                      input int data_w,
                                      input logic is_signed);
        logic signed [MAX_ACC_W-1:0] hi;
        logic signed [MAX_ACC_W-1:0] lo;
        logic [MAX_DW-1:0]           mask;
        red_t                        r;
        mask = MAX_DW'((32'd1 << data_w) - 32'd1);
        if (is_signed) begin
            hi = (40'sd1 <<< (data_w - 1)) - 40'sd1;
            lo = -(40'sd1 <<< (data_w - 1));
        end else begin
            hi = (40'sd1 <<< data_w) - 40'sd1;
            lo = '0;
        end
        r.clip = 1'b0;
        r.val  = acc[MAX_DW-1:0] & mask;
        if (SAT_EN) begin
            if (acc > hi) begin
                r.clip = 1'b1;
                r.val  = hi[MAX_DW-1:0] & mask;
            end else if (acc < lo) begin
                r.clip = 1'b1;
                r.val  = lo[MAX_DW-1:0] & mask;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/matmul_param_unit_mac.sv
// Multiply-accumulate datapath: one product per enabled cycle, reduced output
// and accumulator clear on the last term of a dot product.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int N      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              last,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] elem_o,
    output logic              clip_o
);

    localparam int ACC_W = acc_w_f(DATA_W, N);

    logic [ACC_W-1:0]            acc_q, acc_d;
    logic [ACC_W-1:0]            a_ext, b_ext, prod, sum;
    logic signed [MAX_ACC_W-1:0] sum_ext;
    red_t                        red;

    always_comb begin
        // Low ACC_W bits of the product are correct for both signed and unsigned operands.
        a_ext   = {{(ACC_W-DATA_W){signed_mode & a_i[DATA_W-1]}}, a_i};
        b_ext   = {{(ACC_W-DATA_W){signed_mode & b_i[DATA_W-1]}}, b_i};
        prod    = a_ext * b_ext;
        sum     = acc_q + prod;
        sum_ext = {{(MAX_ACC_W-ACC_W){signed_mode & sum[ACC_W-1]}}, sum};
        red     = reduce_f(sum_ext, DATA_W, signed_mode);
        acc_d   = acc_q;
        if (en) begin
            acc_d = last ? '0 : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign elem_o = red.val[DATA_W-1:0];
    assign clip_o = red.clip;

endmodule

// File: rtl/matmul_param_unit.sv
// Sequential N x N matrix multiplier, one MAC per cycle; result registered on STORE.
// Define MATMUL_SAT_EN to clamp elements and report clipping on sat_flag.
//
// state    | meaning
// ST_IDLE  | waiting for start; operands captured on the start edge
// ST_CALC  | N^3 MAC cycles over i (row), j (column), k (inner)
// ST_STORE | copy elements to result, pulse done
module matmul_param_unit
    import matmul_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int N      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [N*N*DATA_W-1:0]      mat_a,
    input  logic [N*N*DATA_W-1:0]      mat_b,
    output logic [N*N*DATA_W-1:0]      result,
    output logic                       busy,
    output logic                       done,
    output logic                       sat_flag
);

    localparam int CW = $clog2(N);
    localparam int IW = $clog2(N*N);

    state_t state_q, state_d;

    logic [N*N-1:0][DATA_W-1:0] a_q, b_q, elem_q, result_q;
    logic                       sm_q;
    logic [CW-1:0]              i_q, j_q, k_q;
    logic                       clip_acc_q, sat_q, done_q;

    logic          capture, calc, store;
    logic          i_last, j_last, k_last;
    logic [IW-1:0] a_idx, b_idx, w_idx;
    logic [DATA_W-1:0] mac_elem;
    logic          mac_clip;

    assign i_last = (i_q == CW'(N-1));
    assign j_last = (j_q == CW'(N-1));
    assign k_last = (k_q == CW'(N-1));

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        calc    = 1'b0;
        store   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                calc = 1'b1;
                if (i_last && j_last && k_last) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                store   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        a_idx = IW'(int'(i_q) * N + int'(k_q));
        b_idx = IW'(int'(k_q) * N + int'(j_q));
        w_idx = IW'(int'(i_q) * N + int'(j_q));
    end

    matmul_mac #(
        .DATA_W(DATA_W),
        .N     (N)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .en         (calc),
        .last       (k_last),
        .signed_mode(sm_q),
        .a_i        (a_q[a_idx]),
        .b_i        (b_q[b_idx]),
        .elem_o     (mac_elem),
        .clip_o     (mac_clip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            sm_q       <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            elem_q     <= '0;
            clip_acc_q <= 1'b0;
            result_q   <= '0;
            sat_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= store;
            if (capture) begin
                a_q        <= mat_a;
                b_q        <= mat_b;
                sm_q       <= signed_mode;
                clip_acc_q <= 1'b0;
            end
            if (calc) begin
                k_q <= k_last ? '0 : k_q + 1'b1;
                if (k_last) begin
                    j_q <= j_last ? '0 : j_q + 1'b1;
                    if (j_last) begin
                        i_q <= i_last ? '0 : i_q + 1'b1;
                    end
                    elem_q[w_idx] <= mac_elem;
                    clip_acc_q    <= clip_acc_q | mac_clip;
                end
            end
            if (store) begin
                result_q <= elem_q;
                sat_q    <= clip_acc_q;
            end
        end
    end

    assign result   = result_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_matmul_param_unit.sv
// Scoreboard bench for matmul_param_unit: expected products come from an integer
// matrix model; a negedge monitor checks each done against the queue head.
module tb_matmul_param_unit;

    localparam int DW  = 4;
    localparam int N   = 4;
    localparam int TOT = N * N * DW;
    localparam int LAT = N * N * N + 1;

    typedef struct {
        logic [TOT-1:0] res;
        logic           sat;
        int             t0;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [TOT-1:0] mat_a = '0;
    logic [TOT-1:0] mat_b = '0;
    logic [TOT-1:0] result;
    logic           busy, done, sat_flag;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    matmul_param_unit #(.DATA_W(DW), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_mode(signed_mode),
        .mat_a      (mat_a),
        .mat_b      (mat_b),
        .result     (result),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int elem(input logic [TOT-1:0] m, input int r, input int c, input logic sm);
        logic [DW-1:0] x;
        int v;
        x = m[DW*(r*N+c) +: DW];
        v = int'(x);
        if (sm && v >= (1 << (DW-1))) v -= (1 << DW);
        return v;
    endfunction

    function automatic exp_t model(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic sm);
        exp_t e;
        int acc, v, hi, lo;
        logic [31:0] vb;
        e.res = '0;
        e.sat = 1'b0;
        e.t0  = 0;
        hi = sm ? (1 << (DW-1)) - 1 : (1 << DW) - 1;
        lo = sm ? -(1 << (DW-1)) : 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                acc = 0;
                for (int k = 0; k < N; k++) acc += elem(a, r, k, sm) * elem(b, k, c, sm);
                v = acc;
`ifdef MATMUL_SAT_EN
                if (acc > hi) begin v = hi; e.sat = 1'b1; end
                else if (acc < lo) begin v = lo; e.sat = 1'b1; end
`endif
                vb = 32'(v);
                e.res[DW*(r*N+c) +: DW] = vb[DW-1:0];
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("sat_flag", TOT'(sat_flag), TOT'(e.sat));
                chk("latency", TOT'(cyc - e.t0), TOT'(LAT));
                chk("idle_at_done", TOT'(busy), '0);
            end
        end
    end

    // Called at a negedge while idle; returns just after the start-sampling edge.
    task automatic issue(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic sm);
        exp_t e;
        mat_a = a;
        mat_b = b;
        signed_mode = sm;
        start = 1'b1;
        e = model(a, b, sm);
        @(posedge clk);
        #1;
        e.t0 = cyc;
        exp_q.push_back(e);
        start = 1'b0;
        chk("busy_after_start", TOT'(busy), TOT'(1));
        mat_a = {$urandom, $urandom};
        mat_b = {$urandom, $urandom};
        signed_mode = ~sm;
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", TOT'(exp_q.size()), '0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    localparam logic [TOT-1:0] IDENT = 64'h1000_0100_0010_0001;

    initial begin
        int d0;
        logic [TOT-1:0] ones, eights, seq;
        ones   = '1;
        eights = {16{4'h8}};
        seq    = 64'h0123_4567_89AB_CDEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result, '0);
        chk("reset_busy", TOT'(busy), '0);
        chk("reset_done", TOT'(done), '0);
        chk("reset_sat", TOT'(sat_flag), '0);
        rst = 1'b0;
        @(negedge clk);

        issue(IDENT, seq, 1'b0);
        wait_done();
        chk("identity_is_b", result, seq);

        issue(ones, ones, 1'b0);
        wait_done();
        issue(eights, eights, 1'b1);
        wait_done();
        issue(ones, IDENT, 1'b1);
        wait_done();
        chk("neg_one_times_identity", result, ones);
        chk("neg_one_sat", TOT'(sat_flag), '0);

        // Operand changes and a stray start while busy must not disturb the operation.
        d0 = done_cnt;
        issue(64'h2134_0021_7700_1203, 64'h1111_2222_0303_4004, 1'b0);
        repeat (8) @(negedge clk);
        mat_a = ~mat_a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        chk("single_done", TOT'(done_cnt - d0), TOT'(1));

        // Abort mid-CALC.
        issue(seq, seq, 1'b0);
        repeat (19) @(negedge clk);
        void'(exp_q.pop_back());
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", TOT'(busy), '0);
        chk("abort_result", result, '0);
        chk("abort_sat", TOT'(sat_flag), '0);
        repeat (80) @(negedge clk);
        chk("abort_no_done", TOT'(done_cnt - d0), '0);
        issue(IDENT, 64'hFEDC_BA98_7654_3210, 1'b0);
        wait_done();

        for (int t = 0; t < 12; t++) begin
            issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
